// File: rtl/riscv_rf_multiport.sv
// Multi-port integer register file: NRD combinational reads, NWR writes, x0 fixed at zero,
// sequenced post-reset clear. Optional write-through reads via RISCV_MRF_BYPASS_EN.
module riscv_rf_multiport #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2
) (
    input  logic                  i_riscv_mrf_clk,
    input  logic                  i_riscv_mrf_rst,
    input  logic [NWR-1:0]        i_riscv_mrf_we,
    input  logic [NWR*$clog2(NREGS)-1:0] i_riscv_mrf_waddr,
    input  logic [NWR*XLEN-1:0]   i_riscv_mrf_wdata,
    input  logic [NRD*$clog2(NREGS)-1:0] i_riscv_mrf_raddr,
    output logic [NRD*XLEN-1:0]   o_riscv_mrf_rdata,
    output logic                  o_riscv_mrf_ready
);
    localparam int AW = $clog2(NREGS);
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [NRD*XLEN-1:0] rdata_s;

    // Next state: clear sequencing in CLEAR, port writes in RUN (later ports override earlier ones)
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        regs_d  = regs_q;
        if (i_riscv_mrf_rst) begin
            state_d = ST_CLEAR;
            idx_d   = AW'(1);
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    regs_d[idx_q] = {XLEN{1'b0}};
                    idx_d         = idx_q + AW'(1);
                    if (idx_q == AW'(NREGS - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_CLEAR;
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < NWR; k++) begin
                        regs_d[i_riscv_mrf_waddr[k*AW +: AW]] =
                            (i_riscv_mrf_we[k] && (i_riscv_mrf_waddr[k*AW +: AW] != {AW{1'b0}}))
                                ? i_riscv_mrf_wdata[k*XLEN +: XLEN]
                                : regs_d[i_riscv_mrf_waddr[k*AW +: AW]];
                    end
                end
                default: begin
                    state_d = ST_CLEAR;
                    idx_d   = AW'(1);
                end
            endcase
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge i_riscv_mrf_clk) begin
        if (i_riscv_mrf_rst) begin
            state_q <= ST_CLEAR;
            idx_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Register array storage; contents are zeroed by the clear sequence, not by reset
    always_ff @(posedge i_riscv_mrf_clk) begin
        regs_q <= regs_d;
    end

    // Read ports: zero during CLEAR and for x0, otherwise array (or in-flight write data with bypass)
    always_comb begin
        rdata_s = {(NRD*XLEN){1'b0}};
        for (int j = 0; j < NRD; j++) begin
            if ((state_q == ST_RUN) && (i_riscv_mrf_raddr[j*AW +: AW] != {AW{1'b0}})) begin
                rdata_s[j*XLEN +: XLEN] = regs_q[i_riscv_mrf_raddr[j*AW +: AW]];
`ifdef RISCV_MRF_BYPASS_EN
                for (int k = 0; k < NWR; k++) begin
                    rdata_s[j*XLEN +: XLEN] =
                        (i_riscv_mrf_we[k] && (i_riscv_mrf_waddr[k*AW +: AW] == i_riscv_mrf_raddr[j*AW +: AW]))
                            ? i_riscv_mrf_wdata[k*XLEN +: XLEN]
                            : rdata_s[j*XLEN +: XLEN];
                end
`endif
            end else begin
                rdata_s[j*XLEN +: XLEN] = {XLEN{1'b0}};
            end
        end
    end

    assign o_riscv_mrf_rdata = rdata_s;
    assign o_riscv_mrf_ready = (state_q == ST_RUN);

endmodule

// File: tb/tb_riscv_rf_multiport.sv
// Randomised and directed bench for riscv_rf_multiport against an abstract array model.
module tb_riscv_rf_multiport;
    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic                ready;

    logic [XLEN-1:0] mdl [NREGS];
    int clr_left = NREGS - 1;
    int n_tests  = 0;
    int n_fail   = 0;

    riscv_rf_multiport #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .i_riscv_mrf_clk  (clk),
        .i_riscv_mrf_rst  (rst),
        .i_riscv_mrf_we   (we),
        .i_riscv_mrf_waddr(waddr),
        .i_riscv_mrf_wdata(wdata),
        .i_riscv_mrf_raddr(raddr),
        .o_riscv_mrf_rdata(rdata),
        .o_riscv_mrf_ready(ready)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected value of a read given the current model and this cycle's write inputs
    function automatic logic [63:0] exp_read(input logic [AW-1:0] a);
        logic [63:0] r;
        if (clr_left != 0 || a == 0) return 64'd0;
        r = mdl[a];
`ifdef RISCV_MRF_BYPASS_EN
        for (int k = 0; k < NWR; k++)
            if (we[k] && waddr[k*AW +: AW] == a) r = wdata[k*XLEN +: XLEN];
`endif
        return r;
    endfunction

    task automatic set_idle();
        rst = 1'b0; we = '0; waddr = '0; wdata = '0; raddr = '0;
    endtask

    // One clock: check outputs mid-cycle, take the edge, advance the model
    task automatic cycle();
        #2;
        check_eq("ready", {63'd0, ready}, (clr_left == 0) ? 64'd1 : 64'd0);
        for (int j = 0; j < NRD; j++)
            check_eq($sformatf("rdata%0d_x%0d", j, raddr[j*AW +: AW]),
                     rdata[j*XLEN +: XLEN], exp_read(raddr[j*AW +: AW]));
        @(posedge clk);
        #1;
        if (rst) begin
            clr_left = NREGS - 1;
            for (int i = 0; i < NREGS; i++) mdl[i] = 64'd0;
        end else if (clr_left > 0) begin
            clr_left--;
        end else begin
            for (int k = 0; k < NWR; k++)
                if (we[k] && waddr[k*AW +: AW] != 0) mdl[waddr[k*AW +: AW]] = wdata[k*XLEN +: XLEN];
        end
    endtask

    task automatic do_reset(input int n);
        set_idle();
        rst = 1'b1;
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    task automatic wait_ready();
        set_idle();
        for (int n = 0; n < 40 && !ready; n++) cycle();
        check_eq("ready_timeout", {63'd0, ready}, 64'd1);
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NREGS; i++) mdl[i] = 64'd0;

        // Reset, then sweep reads during clear and attempt a write to x5
        do_reset(3);
        for (int i = 0; i < NREGS - 1; i++) begin
            set_idle();
            raddr = {AW'(NREGS - 1 - i), AW'(i + 1)};
            if (i == 4) begin we = 2'b01; waddr = {AW'(0), AW'(5)}; wdata = {64'd0, 64'h1234}; end
            cycle();
        end
        set_idle();
        for (int i = 1; i < NREGS; i++) begin raddr = {AW'(i), AW'(i)}; cycle(); end
        check_eq("ready_after_clear", {63'd0, ready}, 64'd1);
        raddr = {AW'(0), AW'(5)};
        #2 check_eq("x5_clear_write_lost", rdata[63:0], 64'd0);
        cycle();

        // Basic write and read
        set_idle();
        we = 2'b01; waddr = {AW'(0), AW'(7)}; wdata = {64'd0, 64'hDEAD_BEEF_0000_0001};
        cycle();
        set_idle(); raddr = {AW'(0), AW'(7)};
        #2 check_eq("x7_read", rdata[63:0], 64'hDEAD_BEEF_0000_0001);
        check_eq("x0_read", rdata[127:64], 64'd0);
        cycle();

        // Same-address conflict: port 1 wins
        set_idle();
        we = 2'b11; waddr = {AW'(3), AW'(3)}; wdata = {64'h22, 64'h11};
        cycle();
        set_idle(); raddr = {AW'(3), AW'(3)};
        #2 check_eq("x3_conflict", rdata[63:0], 64'h22);
        cycle();

        // x0 writes dropped
        set_idle();
        we = 2'b11; waddr = '0; wdata = {128{1'b1}};
        cycle();
        set_idle();
        #2 check_eq("x0_after_write", rdata[63:0], 64'd0);
        cycle();

        // Bypass / write-through behaviour
        set_idle();
        we = 2'b01; waddr = {AW'(0), AW'(9)}; wdata = {64'd0, 64'h55}; raddr = {AW'(0), AW'(9)};
`ifdef RISCV_MRF_BYPASS_EN
        #2 check_eq("x9_same_cycle", rdata[63:0], 64'h55);
`else
        #2 check_eq("x9_same_cycle", rdata[63:0], 64'd0);
`endif
        cycle();
        set_idle(); raddr = {AW'(0), AW'(9)};
        #2 check_eq("x9_next_cycle", rdata[63:0], 64'h55);
        cycle();

        // Reset at clear index 10, then full-length clear
        do_reset(2);
        set_idle();
        repeat (9) cycle();
        do_reset(1);
        for (int i = 0; i < NREGS - 1; i++) begin
            #2 check_eq("ready_low_after_midclear", {63'd0, ready}, 64'd0);
            cycle();
        end
        wait_ready();

        // Reset in RUN zeroes contents via the clear sequence
        set_idle();
        we = 2'b10; waddr = {AW'(4), AW'(0)}; wdata = {64'h77, 64'd0};
        cycle();
        do_reset(2);
        wait_ready();
        set_idle(); raddr = {AW'(4), AW'(4)};
        #2 check_eq("x4_after_run_reset", rdata[127:64], 64'd0);
        cycle();

        // Randomised traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            set_idle();
            rst = ($urandom_range(0, 399) == 0);
            we  = NWR'($urandom);
            for (int k = 0; k < NWR; k++) begin
                waddr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
                wdata[k*XLEN +: XLEN] = {$urandom, $urandom};
            end
            for (int j = 0; j < NRD; j++)
                raddr[j*AW +: AW] = ($urandom_range(0, 2) == 0) ? waddr[($urandom_range(0, NWR - 1))*AW +: AW]
                                                                 : AW'($urandom_range(0, 7));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
